// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions: ALU command codes, shift types, NZCV indices, FSM states.
// CMP and TST are issued upstream with the SUB and AND codes respectively.
package exe_pkg;

   typedef enum logic [3:0] {
      CMD_NOP = 4'b0000,
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001
   } exe_cmd_t;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_t;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } exe_state_t;

   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
      logic [63:0] d;
      d = {x, x} >> r;
      return d[31:0];
   endfunction

endpackage

// File: rtl/exe_iter_mul.sv
// Iterative shift-add multiplier: MUL_BITS multiplier bits retired per cycle, low 32 bits of product.
module exe_iter_mul #(
   parameter int unsigned MUL_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   localparam int unsigned N  = 32 / MUL_BITS;
   localparam int unsigned CW = $clog2(N);

   logic [31:0]   a_q;
   logic [31:0]   b_q;
   logic [31:0]   acc_q;
   logic [31:0]   partial;
   logic [CW-1:0] count_q;

   always_comb begin
      partial = '0;
      for (int unsigned i = 0; i < MUL_BITS; i++) begin
         if (b_q[i]) partial = partial + (a_q << i);
      end
   end

   // product is the accumulator after this cycle's step; valid as the result when done
   assign done    = busy && (count_q == CW'(N - 1));
   assign product = acc_q + partial;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         busy    <= 1'b0;
         count_q <= '0;
      end else if (start) begin
         busy    <= 1'b1;
         count_q <= '0;
         a_q     <= op_a;
         b_q     <= op_b;
         acc_q   <= '0;
      end else if (busy) begin
         acc_q   <= product;
         a_q     <= a_q << MUL_BITS;
         b_q     <= b_q >> MUL_BITS;
         count_q <= count_q + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/exe_stage_mc.sv
// EXE stage with valid/ready handshake, registered output, iterative MUL, flush and NZCV register.
module exe_stage_mc
   import exe_pkg::*;
#(
   parameter int unsigned MUL_BITS = 2,
   parameter int unsigned BR_SHIFT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  exe_cmd,
   input  logic        s_bit,
   input  logic        mul_en,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] pc,
   input  logic [31:0] val_rn,
   input  logic [31:0] val_rm,
   input  logic        imm,
   input  logic [11:0] shift_operand,
   input  logic [23:0] signed_imm_24,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_result,
   output logic [31:0] br_addr,
   output logic [3:0]  status
);

   exe_state_t  state_q, state_d;
   logic        mem_op, accept, mul_start, mul_done, mul_retire;
   logic        unused_mul_busy, unused_so_bits;
   logic [31:0] mul_product, val2, alu_res, br_target, imm_sext, add_b;
   logic [3:0]  alu_flags;
   logic [32:0] sum;
   logic [4:0]  shamt;
   logic        add_cin, c_new, v_new, mul_s_q;
   logic [31:0] mul_br_q;

   assign mem_op     = mem_r_en | mem_w_en;
   assign in_ready   = !rst && !flush && (state_q == ST_IDLE) && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign mul_start  = accept && mul_en;
   assign mul_retire = (state_q == ST_BUSY) && mul_done;
   assign shamt      = shift_operand[11:7];
   assign imm_sext   = {{8{signed_imm_24[23]}}, signed_imm_24};
   assign br_target  = pc + (imm_sext << BR_SHIFT);
   assign unused_so_bits = ^shift_operand[4:0];

   always_comb begin
      val2 = val_rm << shamt;
      if (mem_op) begin
         val2 = {20'b0, shift_operand};
      end else if (imm) begin
         val2 = ror32({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
      end else begin
         case (shift_t'(shift_operand[6:5]))
            SH_LSR:  val2 = val_rm >> shamt;
            SH_ASR:  val2 = $signed(val_rm) >>> shamt;
            SH_ROR:  val2 = ror32(val_rm, shamt);
            default: val2 = val_rm << shamt;
         endcase
      end
   end

   // One shared adder; subtraction is rn + ~val2 + cin so carry-out is already NOT borrow
   always_comb begin
      add_b   = val2;
      add_cin = 1'b0;
      alu_res = '0;
      c_new   = status[FLAG_C];
      v_new   = status[FLAG_V];
      case (exe_cmd_t'(exe_cmd))
         CMD_ADC: add_cin = status[FLAG_C];
         CMD_SUB: begin add_b = ~val2; add_cin = 1'b1; end
         CMD_SBC: begin add_b = ~val2; add_cin = status[FLAG_C]; end
         default: ;
      endcase
      sum = {1'b0, val_rn} + {1'b0, add_b} + 33'(add_cin);
      case (exe_cmd_t'(exe_cmd))
         CMD_MOV: alu_res = val2;
         CMD_MVN: alu_res = ~val2;
         CMD_AND: alu_res = val_rn & val2;
         CMD_ORR: alu_res = val_rn | val2;
         CMD_EOR: alu_res = val_rn ^ val2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
            alu_res = sum[31:0];
            c_new   = sum[32];
            v_new   = (val_rn[31] == add_b[31]) && (sum[31] != val_rn[31]);
         end
         default: alu_res = '0;
      endcase
      alu_flags = {alu_res[31], (alu_res == '0), c_new, v_new};
   end

   exe_iter_mul #(
      .MUL_BITS(MUL_BITS)
   ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .abort  (flush),
      .op_a   (val_rn),
      .op_b   (val_rm),
      .busy   (unused_mul_busy),
      .done   (mul_done),
      .product(mul_product)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mul_start) state_d = ST_BUSY;
         ST_BUSY: if (flush || mul_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         alu_result <= '0;
         br_addr    <= '0;
         status     <= '0;
         mul_s_q    <= 1'b0;
         mul_br_q   <= '0;
      end else begin
         if (mul_start) begin
            mul_s_q  <= s_bit && !mem_op;
            mul_br_q <= br_target;
         end
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept && !mul_en) begin
            out_valid  <= 1'b1;
            alu_result <= alu_res;
            br_addr    <= br_target;
            if (s_bit && !mem_op) status <= alu_flags;
         end else if (mul_retire) begin
            out_valid  <= 1'b1;
            alu_result <= mul_product;
            br_addr    <= mul_br_q;
            if (mul_s_q) begin
               status[FLAG_N] <= mul_product[31];
               status[FLAG_Z] <= (mul_product == '0);
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed and randomized checks of exe_stage_mc against an arithmetic reference model.
module tb_exe_stage_mc;
   import exe_pkg::*;

   localparam int unsigned MB   = 2;
   localparam int unsigned BS   = 2;
   localparam int unsigned NMUL = 32 / MB;

   typedef struct {
      logic [3:0]  cmd;
      logic        s, mul, mr, mw, im;
      logic [31:0] pc, rn, rm;
      logic [11:0] so;
      logic [23:0] i24;
   } op_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, s_bit, mul_en, mem_r_en, mem_w_en, imm;
   logic        out_valid, out_ready;
   logic [3:0]  exe_cmd, status;
   logic [31:0] pc, val_rn, val_rm, alu_result, br_addr;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm_24;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [3:0]  m_status;

   always #5 clk = ~clk;

   exe_stage_mc #(
      .MUL_BITS(MB),
      .BR_SHIFT(BS)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .exe_cmd(exe_cmd), .s_bit(s_bit), .mul_en(mul_en), .mem_r_en(mem_r_en),
      .mem_w_en(mem_w_en), .pc(pc), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
      .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
      .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
      .br_addr(br_addr), .status(status)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic longint sx(input logic [31:0] a);
      return a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
   endfunction

   function automatic logic [31:0] m_val2(input op_t o);
      longint unsigned x, r;
      if (o.mr || o.mw) return {20'd0, o.so};
      if (o.im) begin
         x = longint'(o.so[7:0]);
         r = 2 * longint'(o.so[11:8]);
         return 32'((x >> r) | (x << (32 - r)));
      end
      x = longint'(o.rm);
      r = longint'(o.so[11:7]);
      case (o.so[6:5])
         2'd0:    return 32'(x << r);
         2'd1:    return 32'(x >> r);
         2'd2:    return o.rm[31] ? ~32'((x ^ 64'hFFFF_FFFF) >> r) : 32'(x >> r);
         default: return 32'((x >> r) | (x << (32 - r)));
      endcase
   endfunction

   // Returns the expected result, branch address and post-retire status for one op
   task automatic model(input op_t o, input logic [3:0] f, output logic [31:0] res,
                        output logic [31:0] br, output logic [3:0] nf);
      longint unsigned u;
      longint          s, ci, bo;
      logic [31:0]     b;
      logic            c, v;
      b  = m_val2(o);
      c  = f[1];
      v  = f[0];
      res = '0;
      br  = 32'(longint'(o.pc) + (o.i24[23] ? longint'(o.i24) - 64'sd16777216 : longint'(o.i24)) * (64'sd1 << BS));
      if (o.mul) begin
         res = 32'(longint'(o.rn) * longint'(o.rm));
      end else begin
         case (o.cmd)
            CMD_MOV: res = b;
            CMD_MVN: res = ~b;
            CMD_AND: res = o.rn & b;
            CMD_ORR: res = o.rn | b;
            CMD_EOR: res = o.rn ^ b;
            CMD_ADD, CMD_ADC: begin
               ci  = (o.cmd == CMD_ADC) ? longint'(f[1]) : 64'sd0;
               u   = longint'(o.rn) + longint'(b) + ci;
               res = 32'(u);
               c   = u > 64'hFFFF_FFFF;
               s   = sx(o.rn) + sx(b) + ci;
               v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            CMD_SUB, CMD_SBC: begin
               bo  = (o.cmd == CMD_SBC) ? longint'(!f[1]) : 64'sd0;
               res = 32'(longint'(o.rn) - longint'(b) - bo);
               c   = longint'(o.rn) >= longint'(b) + bo;
               s   = sx(o.rn) - sx(b) - bo;
               v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: res = '0;
         endcase
      end
      nf = f;
      if (o.s && !(o.mr || o.mw)) nf = o.mul ? {res[31], res == '0, f[1:0]} : {res[31], res == '0, c, v};
   endtask

   function automatic op_t mk(input logic [3:0] cmd, input logic s, mul, input logic [31:0] pcv, rn, rm,
                              input logic im, input logic [11:0] so, input logic [23:0] i24);
      op_t o;
      o.cmd = cmd; o.s = s; o.mul = mul; o.mr = 1'b0; o.mw = 1'b0; o.im = im;
      o.pc = pcv; o.rn = rn; o.rm = rm; o.so = so; o.i24 = i24;
      return o;
   endfunction

   task automatic drive(input op_t o);
      exe_cmd = o.cmd; s_bit = o.s; mul_en = o.mul; mem_r_en = o.mr; mem_w_en = o.mw;
      imm = o.im; pc = o.pc; val_rn = o.rn; val_rm = o.rm; shift_operand = o.so;
      signed_imm_24 = o.i24;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input op_t o);
      int w;
      drive(o);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("accept_wait", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      val_rn = $urandom; val_rm = $urandom; pc = $urandom;
      shift_operand = 12'($urandom); exe_cmd = 4'($urandom);
   endtask

   task automatic run_op(input op_t o);
      logic [31:0] er, eb;
      logic [3:0]  nf;
      int          busy, stalled;
      model(o, m_status, er, eb, nf);
      issue(o);
      busy = 0;
      stalled = 0;
      while (!out_valid && busy < 100) begin
         if (!in_ready) stalled++;
         busy++;
         @(negedge clk);
      end
      chk("latency", busy, o.mul ? NMUL : 0);
      chk("busy_in_ready", stalled, o.mul ? NMUL : 0);
      chk("out_valid", out_valid, 1);
      chk("alu_result", alu_result, er);
      chk("br_addr", br_addr, eb);
      chk("status", status, nf);
      m_status = nf;
   endtask

   initial begin
      op_t         o, o2;
      logic [31:0] e1, e2, eb;
      logic [3:0]  nf;
      int          cnt;
      logic [3:0]  cmds [9];
      cmds = '{CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(mk(CMD_NOP, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0));
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_result", alu_result, 0);
      chk("rst_br_addr", br_addr, 0);
      chk("rst_status", status, 0);
      rst = 1'b0;
      m_status = 4'b0000;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      @(negedge clk);

      run_op(mk(CMD_ADD, 1'b1, 1'b0, 32'h0, 32'd5, 32'd7, 1'b0, 12'h0, 24'h0));
      chk("add_5_7", alu_result, 32'd12);
      chk("add_5_7_nzcv", status, 4'b0000);
      run_op(mk(CMD_SUB, 1'b1, 1'b0, 32'h0, 32'd3, 32'd5, 1'b0, 12'h0, 24'h0));
      chk("sub_3_5", alu_result, 32'hFFFF_FFFE);
      chk("sub_3_5_nzcv", status, 4'b1000);
      run_op(mk(CMD_ADD, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd1, 1'b0, 12'h0, 24'h0));
      chk("add_wrap", alu_result, 32'h0);
      chk("add_wrap_nzcv", status, 4'b0110);
      run_op(mk(CMD_ADC, 1'b1, 1'b0, 32'h0, 32'd1, 32'd1, 1'b0, 12'h0, 24'h0));
      chk("adc_carry", alu_result, 32'd3);
      run_op(mk(CMD_MOV, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 12'h4FF, 24'h0));
      chk("mov_rot_imm", alu_result, 32'hFF00_0000);
      run_op(mk(CMD_MOV, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 12'h001, 24'hFFFFFF));
      chk("branch_back", br_addr, 32'h0000_00FC);
      run_op(mk(CMD_NOP, 1'b0, 1'b1, 32'h0, 32'd1234, 32'd5678, 1'b0, 12'h0, 24'h0));
      chk("mul_1234_5678", alu_result, 32'd7006652);
      run_op(mk(CMD_SUB, 1'b1, 1'b0, 32'h0, 32'd3, 32'd5, 1'b0, 12'h0, 24'h0));

      // back-pressure: held output, blocked accept, then overwrite on release
      @(negedge clk);
      out_ready = 1'b0;
      o  = mk(CMD_ADD, 1'b0, 1'b0, 32'h40, 32'd10, 32'd20, 1'b0, 12'h0, 24'h10);
      o2 = mk(CMD_EOR, 1'b0, 1'b0, 32'h80, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b0, 12'h0, 24'h0);
      model(o, m_status, e1, eb, nf);
      model(o2, m_status, e2, eb, nf);
      issue(o);
      drive(o2);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_result", alu_result, e1);
         chk("hold_in_ready", in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("overwrite_valid", out_valid, 1);
      chk("overwrite_result", alu_result, e2);

      // flush in the fifth BUSY cycle of a MUL that would have set Z
      issue(mk(CMD_NOP, 1'b1, 1'b1, 32'h0, 32'd0, 32'd5, 1'b0, 12'h0, 24'h0));
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_in_ready", in_ready, 1);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_status", status, m_status);
      drive(mk(CMD_ADD, 1'b1, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0, 12'h0, 24'h0));
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_beats_valid", out_valid, 0);
      chk("flush_beats_status", status, m_status);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("flush_no_retire", cnt, 0);

      // reset in the middle of a MUL
      issue(mk(CMD_NOP, 1'b1, 1'b1, 32'h0, 32'd3, 32'd4, 1'b0, 12'h0, 24'h0));
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_result", alu_result, 0);
      chk("mid_rst_br", br_addr, 0);
      chk("mid_rst_status", status, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      rst = 1'b0;
      m_status = 4'b0000;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("mid_rst_no_retire", cnt, 0);

      for (int i = 0; i < 60; i++) begin
         o = mk(cmds[$urandom_range(0, 8)], 1'($urandom), ($urandom_range(0, 4) == 0),
                $urandom, $urandom, $urandom, 1'($urandom), 12'($urandom), 24'($urandom));
         if ($urandom_range(0, 6) == 0) begin
            o.rn = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : 32'h7FFF_FFFF;
            o.rm = 32'($urandom_range(0, 2));
            o.im = 1'b0;
            o.so = 12'h0;
         end
         if ($urandom_range(0, 6) == 0) begin
            if ($urandom_range(0, 1) == 0) o.mr = 1'b1;
            else o.mw = 1'b1;
         end
         run_op(o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
